clock: RTL and testbench

CLOCK -- requirements
Module: clock

---
 rtl/clock.sv | 139 +++++++++++++
 tb/tb_clock.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clock.sv
// -----------------------------------------------------------------------------
// clock -- cascaded seconds / minutes / hours counter.
//
// Purpose:
//   Three identical terminal-count counters are chained. The seconds counter
//   advances on every clk cycle with en high. The minutes counter advances on
//   the seconds rollover strobe. The hours counter advances on the minutes
//   rollover strobe. Each counter loads 0 when it is ticked while at or above
//   its limit, and increments otherwise. The limits may change at any time.
//   A counter that is already above a lowered limit therefore wraps to 0 on
//   its next tick.
//
// Ports:
//   clk            in   1      sole clock, rising edge
//   reset          in   1      synchronous active-high reset
//   en             in   1      count enable (one seconds tick per cycle)
//   count_max      in   WIDTH  terminal value for seconds and minutes
//   count_max_hrs  in   WIDTH  terminal value for hours
//   clr_sec        out  1      seconds rollover strobe (combinational)
//   count_sec      out  WIDTH  seconds value (registered)
//   clr_min        out  1      minutes rollover strobe (combinational)
//   count_min      out  WIDTH  minutes value (registered)
//   clr_hrs        out  1      hours rollover strobe (combinational)
//   count_hrs      out  WIDTH  hours value (registered)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// clock_counter -- one stage of the cascade.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous active-high reset
//   i_tick   in   1      advance request for this stage
//   i_limit  in   WIDTH  terminal value, compared with >=
//   o_clr    out  1      rollover strobe; it also serves as the next stage's tick
//   o_count  out  WIDTH  registered count
// -----------------------------------------------------------------------------
module clock_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic             w_clr;

  // Rollover strobe: ticked while at/above the limit. It is gated by reset so
  // that no downstream stage sees a tick during reset.
  always_comb begin
    w_clr = i_tick & (r_count >= i_limit) & ~reset;
  end

  // Next-count selection: clear on rollover, step on tick, otherwise hold.
  always_comb begin
    w_next = r_count;
    if (w_clr) begin
      w_next = {WIDTH{1'b0}};
    end else if (i_tick) begin
      w_next = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_next = r_count;
    end
  end

  // Count register with synchronous reset taking priority over any tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {WIDTH{1'b0}};
    end else begin
      r_count <= w_next;
    end
  end

  assign o_clr   = w_clr;
  assign o_count = r_count;

endmodule

module clock #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] count_max,
  input  logic [WIDTH-1:0] count_max_hrs,
  output logic             clr_sec,
  output logic [WIDTH-1:0] count_sec,
  output logic             clr_min,
  output logic [WIDTH-1:0] count_min,
  output logic             clr_hrs,
  output logic [WIDTH-1:0] count_hrs
);

  logic w_clr_sec;
  logic w_clr_min;
  logic w_clr_hrs;

  // Seconds: ticked directly by en.
  clock_counter #(.WIDTH(WIDTH)) u_sec (
    .clk     (clk),
    .reset   (reset),
    .i_tick  (en),
    .i_limit (count_max),
    .o_clr   (w_clr_sec),
    .o_count (count_sec)
  );

  // Minutes: ticked by the seconds rollover, so en low also freezes this stage.
  clock_counter #(.WIDTH(WIDTH)) u_min (
    .clk     (clk),
    .reset   (reset),
    .i_tick  (w_clr_sec),
    .i_limit (count_max),
    .o_clr   (w_clr_min),
    .o_count (count_min)
  );

  // Hours: ticked by the minutes rollover and uses its own limit.
  clock_counter #(.WIDTH(WIDTH)) u_hrs (
    .clk     (clk),
    .reset   (reset),
    .i_tick  (w_clr_min),
    .i_limit (count_max_hrs),
    .o_clr   (w_clr_hrs),
    .o_count (count_hrs)
  );

  assign clr_sec = w_clr_sec;
  assign clr_min = w_clr_min;
  assign clr_hrs = w_clr_hrs;

endmodule

// File: tb/tb_clock.sv
// -----------------------------------------------------------------------------
// tb_clock -- self-checking bench for clock.
// A behavioural time-of-day model is kept alongside the DUT and compared on
// every falling edge. Directed scenarios add hand-computed literal checks.
// Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_clock;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         en;
  logic [W-1:0] count_max;
  logic [W-1:0] count_max_hrs;
  logic         clr_sec, clr_min, clr_hrs;
  logic [W-1:0] count_sec, count_min, count_hrs;

  int n_pass  = 0;
  int n_total = 0;

  clock #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .count_max     (count_max),
    .count_max_hrs (count_max_hrs),
    .clr_sec       (clr_sec),
    .count_sec     (count_sec),
    .clr_min       (clr_min),
    .count_min     (count_min),
    .clr_hrs       (clr_hrs),
    .count_hrs     (count_hrs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: a time of day that advances one second per enabled cycle.
  logic [W-1:0] m_sec, m_min, m_hrs;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_sec   <= '0;
      m_min   <= '0;
      m_hrs   <= '0;
      m_valid <= 1'b1;
    end else if (en) begin
      if (m_sec >= count_max) begin
        m_sec <= '0;
        if (m_min >= count_max) begin
          m_min <= '0;
          m_hrs <= (m_hrs >= count_max_hrs) ? '0 : m_hrs + 1;
        end else begin
          m_min <= m_min + 1;
        end
      end else begin
        m_sec <= m_sec + 1;
      end
    end
  end

  // Compare all outputs against the model every cycle, and count strobe pulses.
  int n_clr_sec = 0;
  int n_clr_min = 0;
  always @(negedge clk) begin
    logic e_sec, e_min, e_hrs;
    if (clr_sec === 1'b1) n_clr_sec++;
    if (clr_min === 1'b1) n_clr_min++;
    if (m_valid) begin
      e_sec = en && !reset && (m_sec >= count_max);
      e_min = e_sec && (m_min >= count_max);
      e_hrs = e_min && (m_hrs >= count_max_hrs);
      chk("model_count_sec", count_sec, m_sec);
      chk("model_count_min", count_min, m_min);
      chk("model_count_hrs", count_hrs, m_hrs);
      chk("model_clr_sec", {31'd0, clr_sec}, {31'd0, e_sec});
      chk("model_clr_min", {31'd0, clr_min}, {31'd0, e_min});
      chk("model_clr_hrs", {31'd0, clr_hrs}, {31'd0, e_hrs});
    end
  end

  // Advance n rising edges; return 1 unit after the last edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, "_hrs"}, count_hrs, W'(h));
    chk({name, "_min"}, count_min, W'(m));
    chk({name, "_sec"}, count_sec, W'(s));
  endtask

  task automatic chk_clr(input string name, input bit s, input bit m, input bit h);
    chk({name, "_clr_sec"}, {31'd0, clr_sec}, {31'd0, s});
    chk({name, "_clr_min"}, {31'd0, clr_min}, {31'd0, m});
    chk({name, "_clr_hrs"}, {31'd0, clr_hrs}, {31'd0, h});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
  endtask

  int base;

  initial begin
    reset = 1'b1; en = 1'b0; count_max = 32'd59; count_max_hrs = 32'd23;
    #1;

    // Reset, then 5 idle cycles.
    do_reset();
    cycles(5);
    chk_time("idle", 0, 0, 0);
    chk_clr("idle", 1'b0, 1'b0, 1'b0);

    // 60 seconds: a single seconds rollover, at cycle 60.
    en = 1'b1;
    base = n_clr_sec;
    cycles(59);
    chk_time("sec59", 0, 0, 59);
    #1;
    chk_clr("sec59", 1'b1, 1'b0, 1'b0);
    cycles(1);
    chk_time("sec60", 0, 1, 0);
    chk("sec60_pulses", W'(n_clr_sec - base), 32'd1);

    // Two hours of counting.
    do_reset();
    base = n_clr_min;
    cycles(7200);
    chk_time("two_hours", 2, 0, 0);
    chk("two_hours_clr_min_pulses", W'(n_clr_min - base), 32'd2);

    // Reach 23:59:59 quickly with limit 1 (4 ticks per hour), then with limit 59.
    do_reset();
    count_max = 32'd1;
    cycles(92);
    chk_time("fast_hours", 23, 0, 0);
    count_max = 32'd59;
    cycles(3599);
    chk_time("pre_midnight", 23, 59, 59);
    #1;
    chk_clr("midnight", 1'b1, 1'b1, 1'b1);
    cycles(1);
    chk_time("midnight", 0, 0, 0);

    // Reset during counting, with a limit that would otherwise fire clr_sec.
    do_reset();
    cycles(30);
    chk_time("sec30", 0, 0, 30);
    count_max = 32'd30;
    reset = 1'b1;
    #1;
    chk_clr("in_reset", 1'b0, 1'b0, 1'b0);
    cycles(1);
    chk_time("after_reset", 0, 0, 0);
    reset = 1'b0;
    count_max = 32'd59;
    cycles(1);
    chk_time("resume", 0, 0, 1);

    // Lower the limit below the current count: the next tick wraps to 0.
    do_reset();
    cycles(40);
    chk_time("sec40", 0, 0, 40);
    count_max = 32'd10;
    #1;
    chk_clr("lowered", 1'b1, 1'b0, 1'b0);
    cycles(1);
    chk_time("lowered", 0, 1, 0);

    // Limit 0: every stage stays at 0 and its strobe fires on every tick.
    do_reset();
    count_max = 32'd0;
    count_max_hrs = 32'd0;
    cycles(3);
    chk_time("limit0", 0, 0, 0);
    #1;
    chk_clr("limit0", 1'b1, 1'b1, 1'b1);

    // Freeze with en low, even when the count is at the limit.
    count_max = 32'd59;
    count_max_hrs = 32'd23;
    do_reset();
    cycles(7);
    count_max = 32'd7;
    en = 1'b0;
    #1;
    chk_clr("frozen", 1'b0, 1'b0, 1'b0);
    cycles(4);
    chk_time("frozen", 0, 0, 7);
    en = 1'b1;
    #1;
    chk_clr("unfrozen", 1'b1, 1'b0, 1'b0);
    cycles(1);
    chk_time("unfrozen", 0, 1, 0);
    cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
